// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO pointer blocks.
package fifo_pkg;

    localparam int unsigned GRAY_MAX = 32;

    typedef enum logic [1:0] {IDLE, WAIT, GRANT} wlvl_state_t;

    // Gray->binary prefix XOR over the low 'width' bits; higher bits read as 0.
    function automatic logic [GRAY_MAX-1:0] gray2bin_f(input logic [GRAY_MAX-1:0] gray,
                                                       input int unsigned width);
        logic [GRAY_MAX-1:0] g;
        logic [GRAY_MAX-1:0] bin;
        for (int unsigned j = 0; j < GRAY_MAX; j++) begin
            g[j] = (j < width) ? gray[j] : 1'b0;
        end
        bin[GRAY_MAX-1] = g[GRAY_MAX-1];
        for (int i = GRAY_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ g[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder of configurable width.
module gray2bin
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_c
);

    assign bin_c = WIDTH'(gray2bin_f(GRAY_MAX'(gray), WIDTH));

endmodule

// File: rtl/wptr_level.sv
// Write-domain fill level, almost-full flag and burst-space grant for the async FIFO.
// Optional high-watermark tracking is enabled by defining WLEVEL_HWM_EN.
module wptr_level
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [ADDRSIZE:0] rptr,
    input  logic [ADDRSIZE:0] wptr,
    input  logic              wreq,
    input  logic [ADDRSIZE:0] wreq_len,
    output logic              wgnt,
    output logic              wgnt_err,
    output logic [ADDRSIZE:0] wlevel,
    output logic              walmost_full,
    output logic [ADDRSIZE:0] whwm,
    input  logic              whwm_clr
);

    localparam int unsigned PW    = ADDRSIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [PW-1:0] wq1_rptr;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] space_c;
    logic [PW-1:0] len_q;
    logic [PW-1:0] len_next;
    logic          len_legal_c;
    logic          gnt_next;
    logic          err_next;
    wlvl_state_t   state;
    wlvl_state_t   state_next;

    // Two-flop synchronizer bringing the read pointer into wclk.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr;
            wq2_rptr <= wq1_rptr;
        end
    end

    gray2bin #(.WIDTH(PW)) u_rptr_dec (.gray(wq2_rptr), .bin_c(rbin));
    gray2bin #(.WIDTH(PW)) u_wptr_dec (.gray(wptr),     .bin_c(wbin));

    // Modular subtraction; the lap bit makes wrap-around come out right.
    assign level_next = wbin - rbin;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_next;
            walmost_full <= (level_next >= PW'(AF_THRESH));
        end
    end

    // Space is derived from the lagging read pointer, so it can only under-report.
    assign space_c     = PW'(DEPTH) - wlevel;
    assign len_legal_c = (wreq_len != '0) && (wreq_len <= PW'(DEPTH));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            wgnt     <= 1'b0;
            wgnt_err <= 1'b0;
        end else begin
            state    <= state_next;
            len_q    <= len_next;
            wgnt     <= gnt_next;
            wgnt_err <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        len_next   = len_q;
        gnt_next   = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (wreq) begin
                    if (len_legal_c) begin
                        len_next   = wreq_len;
                        state_next = WAIT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!wreq) begin
                    state_next = IDLE;
                end else if (space_c >= len_q) begin
                    state_next = GRANT;
                    gnt_next   = 1'b1;
                end
            end
            GRANT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef WLEVEL_HWM_EN
    // Clear reloads with the current level and wins over the running max.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            whwm <= '0;
        end else if (whwm_clr) begin
            whwm <= wlevel;
        end else if (level_next > whwm) begin
            whwm <= level_next;
        end
    end
`else
    logic unused_whwm_clr;
    assign unused_whwm_clr = whwm_clr;
    assign whwm            = '0;
`endif

endmodule

// File: tb/tb_wptr_level.sv
// Bench for wptr_level: directed vectors, per-cycle model comparison and literal pins.
module tb_wptr_level;

    logic       wclk     = 1'b0;
    logic       wrst_n   = 1'b0;
    logic [4:0] rptr     = '0;
    logic [4:0] wptr     = '0;
    logic       wreq     = 1'b0;
    logic [4:0] wreq_len = '0;
    logic       whwm_clr = 1'b0;
    logic       wgnt;
    logic       wgnt_err;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic [4:0] whwm;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b0;

    // Model state: rptr history stands in for the synchronizer lag.
    logic [4:0] r1 = '0;
    logic [4:0] r2 = '0;
    int m_level = 0;
    int m_hwm   = 0;
    int plen    = 0;
    bit m_af    = 1'b0;
    bit m_gnt   = 1'b0;
    bit m_err   = 1'b0;
    bit pend    = 1'b0;

    always #5 wclk = ~wclk;

    wptr_level #(.ADDRSIZE(4), .AF_THRESH(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wptr(wptr),
        .wreq(wreq), .wreq_len(wreq_len), .wgnt(wgnt), .wgnt_err(wgnt_err),
        .wlevel(wlevel), .walmost_full(walmost_full), .whwm(whwm), .whwm_clr(whwm_clr)
    );

    function automatic int g2b(input logic [4:0] g);
        int b = 0;
        for (int s = 0; s < 5; s++) b = b ^ int'(g >> s);
        return b;
    endfunction

    function automatic logic [4:0] b2g(input int b);
        logic [4:0] v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic int lvl_of(input logic [4:0] w, input logic [4:0] r);
        return (g2b(w) + 32 - g2b(r)) % 32;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    // Model: wlevel uses wptr now and rptr from two samples back.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r1 <= '0; r2 <= '0;
            m_level <= 0; m_af <= 1'b0; m_hwm <= 0;
            m_gnt <= 1'b0; m_err <= 1'b0; pend <= 1'b0; plen <= 0;
        end else begin
            r1      <= rptr;
            r2      <= r1;
            m_level <= lvl_of(wptr, r2);
            m_af    <= lvl_of(wptr, r2) >= 12;
            m_err   <= !pend && !m_gnt && wreq && !(wreq_len >= 5'd1 && wreq_len <= 5'd16);
            m_gnt   <= pend && wreq && ((16 - m_level) >= plen);
            if (!pend && !m_gnt && wreq && wreq_len >= 5'd1 && wreq_len <= 5'd16) begin
                pend <= 1'b1;
                plen <= int'(wreq_len);
            end else if (pend && (!wreq || ((16 - m_level) >= plen))) begin
                pend <= 1'b0;
            end
`ifdef WLEVEL_HWM_EN
            if (whwm_clr) m_hwm <= m_level;
            else if (lvl_of(wptr, r2) > m_hwm) m_hwm <= lvl_of(wptr, r2);
`endif
        end
    end

    always @(negedge wclk) begin
        if (chk_en) begin
            check("cyc_wlevel", 32'(wlevel), 32'(m_level));
            check("cyc_walmost_full", 32'(walmost_full), 32'(m_af));
            check("cyc_wgnt", 32'(wgnt), 32'(m_gnt));
            check("cyc_wgnt_err", 32'(wgnt_err), 32'(m_err));
            check("cyc_whwm", 32'(whwm), 32'(m_hwm));
        end
    end

    initial begin
        tick(3);
        chk_en = 1'b1;
        check("rst_wlevel", 32'(wlevel), 32'd0);
        check("rst_af", 32'(walmost_full), 32'd0);
        check("rst_wgnt", 32'(wgnt), 32'd0);
        check("rst_wgnt_err", 32'(wgnt_err), 32'd0);
        check("rst_whwm", 32'(whwm), 32'd0);
        wrst_n = 1'b1;

        for (int i = 1; i <= 11; i++) begin
            wptr = b2g(i);
            tick(1);
        end
        check("lvl11", 32'(wlevel), 32'd11);
        check("lvl11_af", 32'(walmost_full), 32'd0);
        wptr = b2g(12);
        tick(1);
        check("lvl12", 32'(wlevel), 32'd12);
        check("lvl12_af", 32'(walmost_full), 32'd1);

        rptr = 5'b00111;
        tick(1);
        check("rlag1", 32'(wlevel), 32'd12);
        tick(1);
        check("rlag2", 32'(wlevel), 32'd12);
        check("rlag2_af", 32'(walmost_full), 32'd1);
        tick(1);
        check("rlag3", 32'(wlevel), 32'd7);
        check("rlag3_af", 32'(walmost_full), 32'd0);

        // Burst request that must wait for four words of drain.
        wptr = b2g(17);
        tick(1);
        check("burst_lvl", 32'(wlevel), 32'd12);
        wreq = 1'b1; wreq_len = 5'd8;
        tick(4);
        check("burst_hold", 32'(wgnt), 32'd0);
        rptr = b2g(9);
        tick(2);
        check("burst_lvl_old", 32'(wlevel), 32'd12);
        tick(1);
        check("burst_lvl8", 32'(wlevel), 32'd8);
        check("burst_gnt_early", 32'(wgnt), 32'd0);
        tick(1);
        check("burst_gnt", 32'(wgnt), 32'd1);
        wreq = 1'b0;
        tick(1);
        check("burst_gnt_end", 32'(wgnt), 32'd0);

        wreq = 1'b1; wreq_len = 5'd0;
        tick(1);
        check("len0_err", 32'(wgnt_err), 32'd1);
        check("len0_gnt", 32'(wgnt), 32'd0);
        wreq = 1'b0;
        tick(1);
        check("len0_err_end", 32'(wgnt_err), 32'd0);
        wreq = 1'b1; wreq_len = 5'd17;
        tick(1);
        check("len17_err", 32'(wgnt_err), 32'd1);
        wreq = 1'b0;
        tick(3);
        check("len17_gnt", 32'(wgnt), 32'd0);

        // Walk both pointers up to the lap boundary, then wrap wptr.
        wptr = b2g(25);
        tick(1);
        check("lvl16", 32'(wlevel), 32'd16);
        rptr = b2g(24);
        tick(3);
        check("lvl1", 32'(wlevel), 32'd1);
        wptr = 5'b10000;
        tick(1);
        check("lvl7", 32'(wlevel), 32'd7);
        rptr = b2g(28);
        tick(3);
        check("wrap_pre", 32'(wlevel), 32'd3);
        wptr = 5'b00000;
        tick(1);
        check("wrap_post", 32'(wlevel), 32'd4);

        wreq = 1'b1; wreq_len = 5'd16;
        tick(3);
        check("wait_pre_rst", 32'(wgnt), 32'd0);
        wrst_n = 1'b0; wreq = 1'b0; wptr = '0; rptr = '0;
        #1;
        check("midrst_lvl", 32'(wlevel), 32'd0);
        check("midrst_gnt", 32'(wgnt), 32'd0);
        tick(2);
        wrst_n = 1'b1;
        tick(3);
        check("postrst_gnt", 32'(wgnt), 32'd0);
        check("postrst_lvl", 32'(wlevel), 32'd0);

        for (int i = 1; i <= 13; i++) begin
            wptr = b2g(i);
            tick(1);
        end
        for (int i = 1; i <= 11; i++) begin
            rptr = b2g(i);
            tick(1);
        end
        tick(3);
        check("drain_lvl", 32'(wlevel), 32'd2);
`ifdef WLEVEL_HWM_EN
        check("hwm_peak", 32'(whwm), 32'd13);
`endif
        whwm_clr = 1'b1;
        tick(1);
        whwm_clr = 1'b0;
`ifdef WLEVEL_HWM_EN
        check("hwm_clr", 32'(whwm), 32'd2);
`endif
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
